// File: rtl/mux_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux controller.
package mux_ctrl_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_1.sv
// Single-bit 8:1 multiplexer, one slice of the shared datapath.
module mux8_1 (
    input  logic [7:0] d,
    input  logic [2:0] s,
    output logic       y
);

    assign y = d[s];

endmodule

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first set request at or after ptr, searching upward mod 8.
module rr_pick8
    import mux_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   win,
    output logic               found
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     off;

    // rot[i] is req[(ptr+i) mod 8], so bit 0 is the current highest priority.
    assign dbl   = {req, req};
    assign rot   = dbl[ptr +: NUM_REQ];
    assign found = |req;

    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign win = ptr + off;

endmodule

// File: rtl/mux8_rr_ctrl.sv
// Round-robin controller sharing an 8:1 mux among eight requesters, with a
// registered valid/ready output word and a one-cycle grant pulse.
module mux8_rr_ctrl
    import mux_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   din,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [SEL_W-1:0]           sel,
    output logic [WIDTH-1:0]           y,
    output logic                       y_valid,
    input  logic                       y_ready,
    output logic                       busy
);

    state_t               state_q;
    state_t               state_d;
    logic [SEL_W-1:0]     ptr_q;
    logic [SEL_W-1:0]     win;
    logic                 found;
    logic                 capture;
    logic [WIDTH-1:0]     y_mux;

    logic [WIDTH-1:0]     y_p0;
    logic [SEL_W-1:0]     sel_p0;
    logic [NUM_REQ-1:0]   gnt_p0;
    logic                 vld_p0;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win   (win),
        .found (found)
    );

    // Bit-sliced datapath: slice b gathers bit b of every source word.
    for (genvar b = 0; b < WIDTH; b++) begin : g_slice
        logic [NUM_REQ-1:0] col;
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_col
            assign col[k] = din[k*WIDTH + b];
        end
        mux8_1 u_mux (
            .d (col),
            .s (win),
            .y (y_mux[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (found) state_d = HOLD;
            HOLD: if (y_ready) state_d = found ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A held word blocks new captures until the consumer takes it.
    always_comb begin
        vld_p0  = (state_q == HOLD);
        capture = found && ((state_q == IDLE) || y_ready);
    end

    // ---- capture stage: winner data, index, grant and pointer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p0   <= '0;
            sel_p0 <= '0;
            gnt_p0 <= '0;
            ptr_q  <= '0;
        end else begin
            gnt_p0 <= capture ? onehot8(win) : '0;
            if (capture) begin
                y_p0   <= y_mux;
                sel_p0 <= win;
                ptr_q  <= win + SEL_W'(1);
            end
        end
    end

    assign y       = y_p0;
    assign sel     = sel_p0;
    assign gnt     = gnt_p0;
    assign y_valid = vld_p0;
    assign busy    = vld_p0;

endmodule

// File: tb/tb_mux8_rr_ctrl.sv
// Scoreboard bench for mux8_rr_ctrl: directed scenarios plus random traffic
// against a queue-free reference arbiter kept in plain integer arithmetic.
module tb_mux8_rr_ctrl;

    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       req;
    logic [8*W-1:0]   din;
    logic [7:0]       gnt;
    logic [2:0]       sel;
    logic [W-1:0]     y;
    logic             y_valid;
    logic             y_ready;
    logic             busy;

    mux8_rr_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [7:0]   g;
        logic [2:0]   s;
        logic [W-1:0] d;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    int           m_ptr;
    bit           m_valid;
    int           m_sel;
    logic [W-1:0] m_y;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_sel   = 0;
        m_y     = '0;
    endtask

    // Reference behaviour for one clock edge; returns the grant expected after it.
    task automatic model_edge(input logic [7:0] r, input logic [8*W-1:0] d,
                              input logic rdy, output logic [7:0] g);
        int  w;
        bit  hit;
        g   = '0;
        hit = 0;
        w   = 0;
        if (!m_valid || rdy) begin
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx = (m_ptr + k) % 8;
                if (!hit && r[idx]) begin
                    hit = 1;
                    w   = idx;
                end
            end
            if (hit) begin
                m_y     = d[w*W +: W];
                m_sel   = w;
                g[w]    = 1'b1;
                m_ptr   = (w + 1) % 8;
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    // Drive inputs now, let one edge pass, and enqueue what the DUT should show after it.
    task automatic step(input logic [7:0] r, input logic [8*W-1:0] d,
                        input logic rdy, input logic rstn);
        exp_t       e;
        logic [7:0] g;
        req     = r;
        din     = d;
        y_ready = rdy;
        rst_n   = rstn;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            g = '0;
        end else begin
            model_edge(r, d, rdy, g);
        end
        e.v = m_valid;
        e.g = g;
        e.s = 3'(m_sel);
        e.d = m_y;
        q.push_back(e);
        #1;
    endtask

    function automatic logic [8*W-1:0] rand_din();
        return {$urandom, $urandom};
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("y_valid", 64'(y_valid), 64'(e.v));
                chk("busy",    64'(busy),    64'(e.v));
                chk("gnt",     64'(gnt),     64'(e.g));
                chk("sel",     64'(sel),     64'(e.s));
                chk("y",       64'(y),       64'(e.d));
            end
        end
    end

    initial begin : driver
        logic [8*W-1:0] d;
        model_reset();
        req     = '0;
        din     = '0;
        y_ready = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("reset_y_valid", 64'(y_valid), 64'd0);
        chk("reset_gnt",     64'(gnt),     64'd0);
        step(8'h00, '0, 1'b0, 1'b0);
        step(8'h00, '0, 1'b0, 1'b0);

        // Single request from source 5.
        d = rand_din();
        d[5*W +: W] = 8'hA5;
        step(8'b0010_0000, d, 1'b1, 1'b1);
        step(8'h00, rand_din(), 1'b1, 1'b1);
        step(8'h00, rand_din(), 1'b1, 1'b1);

        // Fairness with every source requesting.
        for (int i = 0; i < 10; i++) step(8'hFF, rand_din(), 1'b1, 1'b1);
        step(8'h00, rand_din(), 1'b1, 1'b1);

        // Backpressure: capture source 2, stall, then release to source 6.
        step(8'b0000_0100, rand_din(), 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(8'($urandom), rand_din(), 1'b0, 1'b1);
        step(8'b0100_0000, rand_din(), 1'b1, 1'b1);
        step(8'h00, rand_din(), 1'b1, 1'b1);

        // Wrap-around: grant 6 leaves ptr at 7.
        step(8'b0100_0000, rand_din(), 1'b1, 1'b1);
        step(8'b1000_0001, rand_din(), 1'b1, 1'b1);
        step(8'b0000_0001, rand_din(), 1'b1, 1'b1);
        step(8'h00, rand_din(), 1'b1, 1'b1);

        // Random traffic with random backpressure and request density.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
            if ($urandom_range(0, 4) == 0) r = '0;
            step(r, rand_din(), 1'($urandom_range(0, 3) != 0), 1'b1);
        end

        // Asynchronous reset while a word is held and a grant is showing.
        step(8'hFF, rand_din(), 1'b1, 1'b1);
        step(8'hFF, rand_din(), 1'b1, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_y_valid", 64'(y_valid), 64'd0);
        chk("arst_busy",    64'(busy),    64'd0);
        chk("arst_gnt",     64'(gnt),     64'd0);
        chk("arst_y",       64'(y),       64'd0);
        chk("arst_sel",     64'(sel),     64'd0);
        step(8'hFF, rand_din(), 1'b1, 1'b0);
        step(8'b1000_0010, rand_din(), 1'b1, 1'b1);
        step(8'h00, rand_din(), 1'b1, 1'b1);
        step(8'h00, rand_din(), 1'b1, 1'b1);

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux8_rr_ctrl.md
# mux8_rr_ctrl

Round-robin controller that shares the 8:1 multiplexer datapath among eight requesters. Each cycle it picks one pending requester with rotating priority, steers the mux with that index, and captures the selected word into an output register. It presents that word on a valid/ready port and pulses a one-hot grant back to the winning requester. It sits between the per-source request logic and the single downstream consumer of the mux output `y`.

## Interface
- `WIDTH`, default 8: data width per requester and of `y`.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  8: request per source; bit k belongs to source `ik`.
- `din`  in  8*WIDTH: packed source data; source k occupies bits [k*WIDTH +: WIDTH].
- `gnt`  out  8: one-hot, one-cycle pulse to the source whose data was captured.
- `sel`  out  3: index of the source currently held in `y`.
- `y`  out  WIDTH: registered selected data.
- `y_valid`  out  1: `y` holds an unconsumed word.
- `y_ready`  in  1: consumer accepts `y` when it is high in the same cycle as `y_valid`.
- `busy`  out  1: equals `y_valid`.

## Operation
- States:
  - IDLE: `y_valid`=0.
  - HOLD: `y_valid`=1.
- Arbitration (combinational):
  - Search order: ptr, ptr+1, …, ptr+7, all mod 8.
  - The first set `req` bit wins. `found` is high if any `req` bit is set.
- Capture condition: (IDLE and `found`) or (HOLD and `y_ready` and `found`). On a capture edge:
  - `y` ← `din[win]`.
  - `sel` ← win.
  - `gnt` ← one-hot(win) for exactly one cycle.
  - ptr ← win+1 mod 8 (7 wraps to 0).
- HOLD with `y_ready`=1 and `found`=0: go to IDLE. `y` and `sel` keep their last values.
- HOLD with `y_ready`=0: hold all state. `y` and `sel` must not change. `req` changes are ignored.
- IDLE with `found`=0: no change.
- Sources drop `req` on the cycle after `gnt`. A source that keeps `req` high is treated as a new request and is ranked last, because ptr has already passed it.
- `gnt` is 0 in every cycle without a capture.
- Reset values:
  - state IDLE, ptr=0 (source 0 has highest priority first).
  - `y`=0, `sel`=0, `gnt`=0, `y_valid`=0, `busy`=0.
- Reset mid-transfer: the held word is discarded and no `gnt` is issued. Sources re-arbitrate after `rst_n` rises.
- Datapath: WIDTH instances of the existing single-bit `mux8_1`, driven by the combinational winner index, feed the `y` register.

## Timing
- `req` sampled at edge N → `y`, `sel`, `y_valid`, `gnt` valid after edge N. Latency is 1 cycle.
- Back-to-back:
  - When `y_valid`&&`y_ready`&&`found` at edge N, the new word replaces the old one at edge N.
  - `y_valid` stays 1. Throughput is one word per cycle.
- Without a pending request at acceptance, `y_valid` falls after the accepting edge.
- No combinational path from `y_ready` or `req` to any output.

## Structure
- Package `mux_ctrl_pkg` holds:
  - `NUM_REQ`=8 and `SEL_W`=3.
  - State enum {IDLE, HOLD}.
  - A function `onehot8(idx)`.
- Sub-module `rr_pick8`:
  - Inputs: `req`[7:0], `ptr`[2:0].
  - Outputs: `win`[2:0], `found`.
  - Purely combinational rotate/priority-encode/unrotate.
- The top level holds the FSM, ptr, output registers and the `mux8_1` array.

## Test plan
- Reset then single request: `req`=8'b0010_0000, `din` source 5 = 8'hA5, `y_ready`=1. One cycle later `y`=A5, `sel`=5, `gnt`=8'b0010_0000 for one cycle, then `y_valid` falls.
- Fairness: `req`=8'hFF held, `y_ready`=1. Grants come out in order 0,1,…,7,0 on consecutive cycles, and `y_valid` stays 1.
- Backpressure: capture source 2, hold `y_ready`=0 for 5 cycles while `req` changes. `y`, `sel` and `y_valid` are stable and `gnt`=0. Then raise `y_ready` with `req` bit 6 set: `sel`=6 on the next cycle.
- Wrap-around: ptr=7 (after a grant to 6), `req`=8'b1000_0001. Source 7 wins, then source 0.
- Async reset while `y_valid`=1: `y_valid`, `gnt`, `y` and `sel` go to 0 immediately without a clock. After release, `req`=8'b1000_0010 grants source 1 first (ptr=0).
